// File: rtl/wt_cache_pkg.sv
// Shared types for the write-through dcache to L1.5 store path: request
// struct, size encodings and the big-endian data swizzle.
package wt_cache_pkg;

    localparam int unsigned PADDR_W    = 56;
    localparam int unsigned L15_ADDR_W = 40;
    localparam int unsigned TID_W      = 2;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_D = 2'd3
    } st_size_e;

    typedef enum logic [2:0] {
        L15_SIZE_1B = 3'b000,
        L15_SIZE_2B = 3'b001,
        L15_SIZE_4B = 3'b010,
        L15_SIZE_8B = 3'b011
    } l15_size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } issue_state_e;

    typedef struct packed {
        logic [PADDR_W-1:0] paddr;
        logic [63:0]        data;
        st_size_e           size;
        logic [TID_W-1:0]   tid;
    } wt_l15_st_req_t;

    // Pick the size-aligned field out of the little-endian lanes, fill all
    // 64 bits with copies of it, then present the bytes in big-endian order.
    function automatic logic [63:0] swizzle_be(input logic [63:0] data,
                                               input logic [2:0]  off,
                                               input st_size_e    size);
        logic [63:0] rep;
        logic [63:0] res;
        case (size)
            SIZE_B:  rep = {8{data[{off, 3'b000} +: 8]}};
            SIZE_H:  rep = {4{data[{off[2:1], 4'b0000} +: 16]}};
            SIZE_W:  rep = {2{data[{off[2], 5'b00000} +: 32]}};
            default: rep = data;
        endcase
        for (int i = 0; i < 8; i++) begin
            res[i*8 +: 8] = rep[(7-i)*8 +: 8];
        end
        return res;
    endfunction

    function automatic logic is_aligned(input logic [2:0] off, input st_size_e size);
        case (size)
            SIZE_H:  return off[0] == 1'b0;
            SIZE_W:  return off[1:0] == 2'b00;
            SIZE_D:  return off == 3'b000;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/fifo_v3.sv
// Small synchronous FIFO used as the input skid buffer; DEPTH must be a
// power of two of at least 2 so the pointers wrap naturally.
module fifo_v3 #(
    parameter int unsigned DEPTH = 2,
    parameter type         dtype = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  dtype data_i,
    input  logic pop_i,
    output dtype data_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    dtype              mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W:0]   cnt_q;
    logic              push_ok;
    logic              pop_ok;

    assign full_o  = (cnt_q == (ADDR_W+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + (ADDR_W+1)'(1);
                2'b01:   cnt_q <= cnt_q - (ADDR_W+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // NOTE: storage has no reset; an entry is only read after it was written,
    // so clearing it would buy nothing but reset fan-out.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/wt_l15_store_adapter.sv
// Turns committed write-buffer stores into big-endian L1.5 store requests,
// bounds the stores in flight and returns per-TID acks.
module wt_l15_store_adapter
    import wt_cache_pkg::*;
#(
    parameter int unsigned MAX_OUT    = 7,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [PADDR_W-1:0]    req_paddr_i,
    input  logic [63:0]           req_data_i,
    input  logic [1:0]            req_size_i,
    input  logic [TID_W-1:0]      req_tid_i,
    output logic                  l15_val_o,
    input  logic                  l15_ack_i,
    output logic [L15_ADDR_W-1:0] l15_address_o,
    output logic [63:0]           l15_data_o,
    output logic [2:0]            l15_size_o,
    output logic [TID_W-1:0]      l15_threadid_o,
    input  logic                  l15_st_ack_i,
    input  logic [TID_W-1:0]      l15_st_ack_tid_i,
    output logic                  ack_valid_o,
    output logic [TID_W-1:0]      ack_tid_o,
    output logic                  idle_o,
    output logic                  err_o
);

    localparam int unsigned      CNT_W   = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

    wt_l15_st_req_t        fifo_in;
    wt_l15_st_req_t        fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic                  latch_head;
    logic                  issue_ack;

    issue_state_e          state_q,  state_d;
    logic [CNT_W-1:0]      out_cnt_q, out_cnt_d;
    logic                  err_q,    err_d;
    logic [L15_ADDR_W-1:0] addr_q;
    logic [63:0]           data_q;
    l15_size_e             size_q;
    logic [TID_W-1:0]      tid_q;
    logic                  ack_valid_q;
    logic [TID_W-1:0]      ack_tid_q;
    logic                  unused_paddr_hi;

    assign fifo_in = '{paddr: req_paddr_i, data: req_data_i,
                       size: st_size_e'(req_size_i), tid: req_tid_i};

    // Ready depends only on FIFO occupancy, never on l15_ack_i.
    assign req_ready_o = !fifo_full;

    fifo_v3 #(
        .DEPTH (FIFO_DEPTH),
        .dtype (wt_l15_st_req_t)
    ) i_skid_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (req_valid_i && req_ready_o),
        .data_i  (fifo_in),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign unused_paddr_hi = ^fifo_head.paddr[PADDR_W-1:L15_ADDR_W];

    // NOTE: every signal driven here gets a default first so no path through
    // the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        latch_head = 1'b0;
        fifo_pop   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && (out_cnt_q < CNT_MAX)) begin
                    state_d    = ST_SEND;
                    latch_head = 1'b1;
                end
            end
            ST_SEND: begin
                if (l15_ack_i) begin
                    state_d  = ST_IDLE;
                    fifo_pop = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign issue_ack = (state_q == ST_SEND) && l15_ack_i;

    always_comb begin
        out_cnt_d = out_cnt_q;
        err_d     = err_q;
        if (l15_st_ack_i && (out_cnt_q == '0)) err_d = 1'b1;
        case ({issue_ack, l15_st_ack_i})
            2'b10:   out_cnt_d = out_cnt_q + CNT_W'(1);
            2'b01:   if (out_cnt_q != '0) out_cnt_d = out_cnt_q - CNT_W'(1);
            default: out_cnt_d = out_cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            out_cnt_q   <= '0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            size_q      <= L15_SIZE_1B;
            tid_q       <= '0;
            ack_valid_q <= 1'b0;
            ack_tid_q   <= '0;
        end else begin
            state_q     <= state_d;
            out_cnt_q   <= out_cnt_d;
            err_q       <= err_d;
            ack_valid_q <= l15_st_ack_i;
            ack_tid_q   <= l15_st_ack_tid_i;
            if (latch_head) begin
                addr_q <= fifo_head.paddr[L15_ADDR_W-1:0];
                data_q <= swizzle_be(fifo_head.data, fifo_head.paddr[2:0], fifo_head.size);
                size_q <= l15_size_e'({1'b0, fifo_head.size});
                tid_q  <= fifo_head.tid;
            end
        end
    end

    assign l15_val_o      = (state_q == ST_SEND);
    assign l15_address_o  = addr_q;
    assign l15_data_o     = data_q;
    assign l15_size_o     = size_q;
    assign l15_threadid_o = tid_q;
    assign ack_valid_o    = ack_valid_q;
    assign ack_tid_o      = ack_tid_q;
    assign err_o          = err_q;
    assign idle_o         = fifo_empty && (state_q == ST_IDLE) && (out_cnt_q == '0);

    // Misaligned stores are the write buffer's responsibility.
    req_aligned_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (req_valid_i && req_ready_o) |-> is_aligned(req_paddr_i[2:0], st_size_e'(req_size_i)));

    val_stable_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (l15_val_o && !l15_ack_i) |=> (l15_val_o && $stable(l15_data_o)
                                       && $stable(l15_address_o) && $stable(l15_threadid_o)));

endmodule

// File: tb/tb_wt_l15_store_adapter.sv
// Directed and randomised-backpressure bench for wt_l15_store_adapter.
module tb_wt_l15_store_adapter;
    import wt_cache_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [55:0] req_paddr_i = '0;
    logic [63:0] req_data_i = '0;
    logic [1:0]  req_size_i = '0;
    logic [1:0]  req_tid_i = '0;
    logic        l15_val_o;
    logic        l15_ack_i = 1'b0;
    logic [39:0] l15_address_o;
    logic [63:0] l15_data_o;
    logic [2:0]  l15_size_o;
    logic [1:0]  l15_threadid_o;
    logic        l15_st_ack_i = 1'b0;
    logic [1:0]  l15_st_ack_tid_i = '0;
    logic        ack_valid_o;
    logic [1:0]  ack_tid_o;
    logic        idle_o;
    logic        err_o;

    int n_checks = 0;
    int n_fail   = 0;
    int hs_cnt   = 0;
    int bench_out = 0;

    typedef struct {
        logic [55:0] paddr;
        logic [63:0] data;
        logic [1:0]  size;
        logic [1:0]  tid;
        logic [63:0] exp;
    } st_t;

    st_t send_q[$];
    st_t exp_q[$];

    always #5 clk_i = ~clk_i;

    wt_l15_store_adapter dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_paddr_i      (req_paddr_i),
        .req_data_i       (req_data_i),
        .req_size_i       (req_size_i),
        .req_tid_i        (req_tid_i),
        .l15_val_o        (l15_val_o),
        .l15_ack_i        (l15_ack_i),
        .l15_address_o    (l15_address_o),
        .l15_data_o       (l15_data_o),
        .l15_size_o       (l15_size_o),
        .l15_threadid_o   (l15_threadid_o),
        .l15_st_ack_i     (l15_st_ack_i),
        .l15_st_ack_tid_i (l15_st_ack_tid_i),
        .ack_valid_o      (ack_valid_o),
        .ack_tid_o        (ack_tid_o),
        .idle_o           (idle_o),
        .err_o            (err_o)
    );

    // Output byte j (big-endian) takes source byte base + ((7-j) mod n).
    function automatic logic [63:0] model_be(input logic [63:0] d, input logic [2:0] off,
                                             input logic [1:0] sz);
        logic [63:0] r;
        int n;
        int base;
        n    = 1 << sz;
        base = (int'(off) / n) * n;
        for (int j = 0; j < 8; j++) begin
            r[j*8 +: 8] = d[(base + ((7 - j) % n))*8 +: 8];
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid_i  = 1'b0;
        l15_ack_i    = 1'b0;
        l15_st_ack_i = 1'b0;
    endtask

    task automatic mk_store(input logic [55:0] paddr, input logic [63:0] data,
                            input logic [1:0] size, input logic [1:0] tid);
        st_t s;
        s.paddr = paddr;
        s.data  = data;
        s.size  = size;
        s.tid   = tid;
        s.exp   = model_be(data, paddr[2:0], size);
        send_q.push_back(s);
    endtask

    task automatic wait_val(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (l15_val_o) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic st_ack_t(input logic [1:0] tid);
        l15_st_ack_i     = 1'b1;
        l15_st_ack_tid_i = tid;
        tick();
        l15_st_ack_i = 1'b0;
        if (bench_out > 0) bench_out--;
        n_checks++;
        if (ack_valid_o !== 1'b1 || ack_tid_o !== tid) begin
            n_fail++;
            $display("FAIL st_ack: ack_valid=%b tid=%0d, need 1/%0d", ack_valid_o, ack_tid_o, tid);
        end
        tick();
        n_checks++;
        if (ack_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_pulse: ack_valid=%b, need 0", ack_valid_o);
        end
    endtask

    // Per-cycle engine: feeds send_q, acks the L1.5 side, scoreboards issues.
    task automatic run(input int max_cycles, input int target, input bit rnd);
        bit          hold;
        logic [39:0] s_addr;
        logic [63:0] s_data;
        logic [2:0]  s_size;
        logic [1:0]  s_tid;
        hold = 1'b0;
        for (int c = 0; c < max_cycles && hs_cnt < target; c++) begin
            bit         push;
            bit         hs;
            bit         st;
            logic [1:0] st_tid;
            req_valid_i = (send_q.size() > 0) && (!rnd || $urandom_range(0, 3) != 0);
            if (send_q.size() > 0) begin
                req_paddr_i = send_q[0].paddr;
                req_data_i  = send_q[0].data;
                req_size_i  = send_q[0].size;
                req_tid_i   = send_q[0].tid;
            end
            l15_ack_i        = l15_val_o && (!rnd || $urandom_range(0, 2) != 0);
            st               = rnd && (bench_out > 0) && ($urandom_range(0, 1) == 0);
            st_tid           = 2'($urandom_range(0, 3));
            l15_st_ack_i     = st;
            l15_st_ack_tid_i = st_tid;
            if (hold) begin
                n_checks++;
                if (l15_val_o !== 1'b1 || l15_address_o !== s_addr || l15_data_o !== s_data
                    || l15_size_o !== s_size || l15_threadid_o !== s_tid) begin
                    n_fail++;
                    $display("FAIL hold_stable: val=%b data=%h, need 1/%h", l15_val_o, l15_data_o, s_data);
                end
            end
            push = req_valid_i && req_ready_o;
            hs   = l15_val_o && l15_ack_i;
            if (hs) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL spurious_issue: data=%h with nothing queued", l15_data_o);
                end else if (l15_data_o !== exp_q[0].exp || l15_address_o !== exp_q[0].paddr[39:0]
                             || l15_size_o !== {1'b0, exp_q[0].size}
                             || l15_threadid_o !== exp_q[0].tid) begin
                    n_fail++;
                    $display("FAIL issue_order: addr=%h data=%h size=%0d tid=%0d, need %h %h %0d %0d",
                             l15_address_o, l15_data_o, l15_size_o, l15_threadid_o,
                             exp_q[0].paddr[39:0], exp_q[0].exp, exp_q[0].size, exp_q[0].tid);
                end
            end
            hold   = l15_val_o && !l15_ack_i;
            s_addr = l15_address_o;
            s_data = l15_data_o;
            s_size = l15_size_o;
            s_tid  = l15_threadid_o;
            tick();
            if (push) exp_q.push_back(send_q.pop_front());
            if (hs) begin
                if (exp_q.size() > 0) exp_q.delete(0);
                hs_cnt++;
                bench_out++;
            end
            if (st) bench_out--;
            n_checks++;
            if (ack_valid_o !== st || (st && ack_tid_o !== st_tid)) begin
                n_fail++;
                $display("FAIL ack_return: valid=%b tid=%0d, need %b/%0d", ack_valid_o, ack_tid_o, st, st_tid);
            end
        end
        clear_inputs();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk_i);
        #1;
        n_checks++;
        if (req_ready_o !== 1'b1 || idle_o !== 1'b1 || l15_val_o !== 1'b0 || ack_valid_o !== 1'b0
            || err_o !== 1'b0 || l15_data_o !== 64'h0 || l15_address_o !== 40'h0
            || l15_size_o !== 3'd0 || l15_threadid_o !== 2'd0 || ack_tid_o !== 2'd0) begin
            n_fail++;
            $display("FAIL reset: ready=%b idle=%b val=%b ackv=%b err=%b data=%h, need 1 1 0 0 0 0",
                     req_ready_o, idle_o, l15_val_o, ack_valid_o, err_o, l15_data_o);
        end
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_single(input string name, input logic [55:0] paddr, input logic [63:0] data,
                               input logic [1:0] size, input logic [1:0] tid, input logic [63:0] exp);
        bit ok;
        req_valid_i = 1'b1;
        req_paddr_i = paddr;
        req_data_i  = data;
        req_size_i  = size;
        req_tid_i   = tid;
        n_checks++;
        if (req_ready_o !== 1'b1 || l15_val_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_accept: ready=%b val=%b, need 1/0", name, req_ready_o, l15_val_o);
        end
        tick();
        req_valid_i = 1'b0;
        wait_val(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_timeout: l15_val_o never rose", name);
        end
        n_checks++;
        if (l15_data_o !== exp) begin
            n_fail++;
            $display("FAIL %s_data: got %h need %h", name, l15_data_o, exp);
        end
        n_checks++;
        if (l15_address_o !== paddr[39:0] || l15_size_o !== {1'b0, size} || l15_threadid_o !== tid) begin
            n_fail++;
            $display("FAIL %s_fields: addr=%h size=%0d tid=%0d need %h %0d %0d",
                     name, l15_address_o, l15_size_o, l15_threadid_o, paddr[39:0], size, tid);
        end
        tick();
        n_checks++;
        if (l15_val_o !== 1'b1 || l15_data_o !== exp || l15_address_o !== paddr[39:0]) begin
            n_fail++;
            $display("FAIL %s_hold: val=%b data=%h need 1/%h", name, l15_val_o, l15_data_o, exp);
        end
        l15_ack_i = 1'b1;
        tick();
        l15_ack_i = 1'b0;
        bench_out++;
        n_checks++;
        if (l15_val_o !== 1'b0 || idle_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_issued: val=%b idle=%b need 0/0", name, l15_val_o, idle_o);
        end
        st_ack_t(tid);
        n_checks++;
        if (idle_o !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_idle: idle=%b need 1", name, idle_o);
        end
    endtask

    task automatic test_swizzle();
        test_single("sb", 56'h0000_0000_8000_0003, 64'h0000_0000_AB00_0000, 2'd0, 2'd1, 64'hABAB_ABAB_ABAB_ABAB);
        test_single("sd", 56'h0000_0000_0000_1000, 64'h0011_2233_4455_6677, 2'd3, 2'd2, 64'h7766_5544_3322_1100);
        test_single("sh", 56'hAB_CD12_3456_1006,   64'hBEEF_0000_0000_0000, 2'd1, 2'd3, 64'hEFBE_EFBE_EFBE_EFBE);
        test_single("sw", 56'h0000_0000_0000_0004, 64'h1234_5678_0000_0000, 2'd2, 2'd0, 64'h7856_3412_7856_3412);
    endtask

    task automatic test_outstanding_limit();
        hs_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            mk_store(56'h2000 + 56'(i * 8), {32'hC0DE_0000 | 32'(i), 32'(i * 3)}, 2'd3, 2'(i % 4));
        end
        run(80, 9, 1'b0);
        n_checks++;
        if (hs_cnt != 7) begin
            n_fail++;
            $display("FAIL limit_handshakes: got %0d need 7", hs_cnt);
        end
        n_checks++;
        if (req_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL limit_full: ready=%b need 0", req_ready_o);
        end
        st_ack_t(2'd0);
        run(30, 9, 1'b0);
        n_checks++;
        if (hs_cnt != 8) begin
            n_fail++;
            $display("FAIL limit_eighth: got %0d need 8", hs_cnt);
        end
        st_ack_t(2'd1);
        run(30, 9, 1'b0);
        for (int i = 0; i < 7; i++) st_ack_t(2'(i % 4));
        n_checks++;
        if (hs_cnt != 9 || idle_o !== 1'b1 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL limit_drain: hs=%0d idle=%b err=%b need 9/1/0", hs_cnt, idle_o, err_o);
        end
    endtask

    task automatic test_simultaneous();
        bit ok;
        hs_cnt = 0;
        for (int i = 0; i < 4; i++) mk_store(56'h3000 + 56'(i * 4), 64'hFACE_0000_CAFE_0000, 2'd2, 2'(i));
        run(40, 3, 1'b0);
        wait_val(ok);
        n_checks++;
        if (!ok || hs_cnt != 3) begin
            n_fail++;
            $display("FAIL simul_setup: val_seen=%b hs=%0d need 1/3", ok, hs_cnt);
        end
        l15_ack_i        = 1'b1;
        l15_st_ack_i     = 1'b1;
        l15_st_ack_tid_i = 2'd3;
        tick();
        clear_inputs();
        exp_q.delete(0);
        n_checks++;
        if (ack_valid_o !== 1'b1 || ack_tid_o !== 2'd3) begin
            n_fail++;
            $display("FAIL simul_ack: valid=%b tid=%0d need 1/3", ack_valid_o, ack_tid_o);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            st_ack_t(2'(i));
            n_checks++;
            if (idle_o !== (i == 2) || err_o !== 1'b0) begin
                n_fail++;
                $display("FAIL simul_count_%0d: idle=%b err=%b need %b/0", i, idle_o, err_o, i == 2);
            end
        end
    endtask

    task automatic test_ack_order();
        hs_cnt = 0;
        mk_store(56'h4000, 64'h1, 2'd3, 2'd2);
        mk_store(56'h4008, 64'h2, 2'd3, 2'd0);
        mk_store(56'h4010, 64'h3, 2'd3, 2'd1);
        run(40, 3, 1'b0);
        tick();
        n_checks++;
        if (hs_cnt != 3 || ack_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL order_setup: hs=%0d ack_valid=%b need 3/0", hs_cnt, ack_valid_o);
        end
        st_ack_t(2'd2);
        st_ack_t(2'd0);
        st_ack_t(2'd1);
        n_checks++;
        if (idle_o !== 1'b1) begin
            n_fail++;
            $display("FAIL order_idle: idle=%b need 1", idle_o);
        end
    endtask

    task automatic test_err();
        st_ack_t(2'd3);
        n_checks++;
        if (err_o !== 1'b1 || idle_o !== 1'b1) begin
            n_fail++;
            $display("FAIL err_set: err=%b idle=%b need 1/1", err_o, idle_o);
        end
        repeat (3) tick();
        n_checks++;
        if (err_o !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: err=%b need 1", err_o);
        end
        hs_cnt = 0;
        mk_store(56'h5000, 64'h55, 2'd0, 2'd1);
        run(30, 1, 1'b0);
        n_checks++;
        if (hs_cnt != 1 || idle_o !== 1'b0) begin
            n_fail++;
            $display("FAIL err_no_wrap: hs=%0d idle=%b need 1/0", hs_cnt, idle_o);
        end
        st_ack_t(2'd1);
        n_checks++;
        if (idle_o !== 1'b1 || err_o !== 1'b1) begin
            n_fail++;
            $display("FAIL err_recount: idle=%b err=%b need 1/1", idle_o, err_o);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        req_valid_i = 1'b1;
        req_paddr_i = 56'h6000;
        req_data_i  = 64'hDEAD_BEEF_0123_4567;
        req_size_i  = 2'd3;
        req_tid_i   = 2'd2;
        tick();
        req_valid_i = 1'b1;
        req_paddr_i = 56'h6008;
        tick();
        req_valid_i = 1'b0;
        wait_val(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rstmid_setup: l15_val_o never rose");
        end
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if (l15_val_o !== 1'b0 || idle_o !== 1'b1 || req_ready_o !== 1'b1 || err_o !== 1'b0
            || l15_data_o !== 64'h0 || l15_address_o !== 40'h0 || ack_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: val=%b idle=%b ready=%b err=%b data=%h need 0 1 1 0 0",
                     l15_val_o, idle_o, req_ready_o, err_o, l15_data_o);
        end
        tick();
        rst_ni = 1'b1;
        repeat (5) tick();
        n_checks++;
        if (l15_val_o !== 1'b0 || idle_o !== 1'b1 || ack_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_dropped: val=%b idle=%b ackv=%b need 0/1/0", l15_val_o, idle_o, ack_valid_o);
        end
        send_q.delete();
        exp_q.delete();
        bench_out = 0;
    endtask

    task automatic test_random();
        hs_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            logic [63:0] r;
            logic [1:0]  sz;
            logic [2:0]  off;
            r   = {$urandom, $urandom};
            sz  = 2'($urandom_range(0, 3));
            off = 3'($urandom_range(0, 7));
            off = (off >> sz) << sz;
            mk_store({r[55:3], off}, {$urandom, $urandom}, sz, 2'($urandom_range(0, 3)));
        end
        run(30000, 1000, 1'b1);
        n_checks++;
        if (hs_cnt != 1000 || send_q.size() != 0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL random_complete: hs=%0d pending=%0d/%0d need 1000/0/0",
                     hs_cnt, send_q.size(), exp_q.size());
        end
        while (bench_out > 0) st_ack_t(2'($urandom_range(0, 3)));
        n_checks++;
        if (idle_o !== 1'b1 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL random_drain: idle=%b err=%b need 1/0", idle_o, err_o);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_swizzle();
        test_outstanding_limit();
        test_simultaneous();
        test_ack_order();
        test_err();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
